// File: rtl/synth_audio_pkg.sv
// rtl/synth_audio_pkg.sv - shared audio constants and channel encoding
// Purpose: default word widths and the LRCK channel encoding used by the
//          synth audio path.
// Ports:   none (package).
package synth_audio_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int UNDERRUN_W_DEF = 8;

  // LRCK level meaning: low selects the left channel, high the right.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

endpackage

// File: rtl/audio_edge_det.sv
// rtl/audio_edge_det.sv - registered level with rise/fall pulse detection
// Purpose: samples one AUDIO_CLK-synchronous control signal once and flags
//          its edges for one cycle.
// Ports:   AUDIO_CLK  in   system audio clock
//          iRST_N     in   asynchronous active-low reset
//          i_sig      in   signal to watch
//          o_level    out  registered copy of i_sig
//          o_rise     out  one-cycle pulse, previous 0 / current 1
//          o_fall     out  one-cycle pulse, previous 1 / current 0
module audio_edge_det (
  input  logic AUDIO_CLK,
  input  logic iRST_N,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_cur;
  logic r_prev;

  always_ff @(posedge AUDIO_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= i_sig;
      r_prev <= r_cur;
    end
  end

  assign o_level = r_cur;
  assign o_rise  = r_cur & ~r_prev;
  assign o_fall  = ~r_cur & r_prev;

endmodule

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - I2S DAC serializer with one-pair holding buffer
// Purpose: shifts stereo samples out MSB first on BCK falling edges with the
//          I2S one-bit delay after each LRCK change; tracks underruns.
// Ports:   AUDIO_CLK      in   system audio clock
//          iRST_N         in   asynchronous active-low reset
//          iAUD_BCK       in   bit clock (AUDIO_CLK-synchronous)
//          iLRCK          in   word clock, 0 = left, 1 = right
//          iSAMPLE_L/R    in   stereo pair, two's complement
//          iSAMPLE_VALID  in   producer offers a pair
//          oSAMPLE_READY  out  holding buffer empty
//          iMUTE          in   zero both words of the frame starting now
//          oAUD_DACDAT    out  serial data
//          oFRAME_START   out  pulse on each left-channel load
//          oUNDERRUN      out  pulse on a frame start with empty buffer
//          oUNDERRUN_CNT  out  saturating underrun count
module audio_dac_serializer
  import synth_audio_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int UNDERRUN_W = UNDERRUN_W_DEF
) (
  input  logic                  AUDIO_CLK,
  input  logic                  iRST_N,
  input  logic                  iAUD_BCK,
  input  logic                  iLRCK,
  input  logic [DATA_WIDTH-1:0] iSAMPLE_L,
  input  logic [DATA_WIDTH-1:0] iSAMPLE_R,
  input  logic                  iSAMPLE_VALID,
  output logic                  oSAMPLE_READY,
  input  logic                  iMUTE,
  output logic                  oAUD_DACDAT,
  output logic                  oFRAME_START,
  output logic                  oUNDERRUN,
  output logic [UNDERRUN_W-1:0] oUNDERRUN_CNT
);

  logic w_bck_fall;
  logic w_bck_level_unused;
  logic w_bck_rise_unused;
  logic w_lrck;
  logic w_lrck_rise_unused;
  logic w_lrck_fall_unused;

  audio_edge_det u_bck_det (
    .AUDIO_CLK (AUDIO_CLK),
    .iRST_N    (iRST_N),
    .i_sig     (iAUD_BCK),
    .o_level   (w_bck_level_unused),
    .o_rise    (w_bck_rise_unused),
    .o_fall    (w_bck_fall)
  );

  audio_edge_det u_lrck_det (
    .AUDIO_CLK (AUDIO_CLK),
    .iRST_N    (iRST_N),
    .i_sig     (iLRCK),
    .o_level   (w_lrck),
    .o_rise    (w_lrck_rise_unused),
    .o_fall    (w_lrck_fall_unused)
  );

  logic                  r_lrck_latched;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_act_l;
  logic [DATA_WIDTH-1:0] r_act_r;
  logic [DATA_WIDTH-1:0] r_buf_l;
  logic [DATA_WIDTH-1:0] r_buf_r;
  logic                  r_buf_full;
  logic                  r_dacdat;
  logic                  r_frame_start;
  logic                  r_underrun;
  logic [UNDERRUN_W-1:0] r_underrun_cnt;

  // A boundary is judged against the LRCK seen at the previous bit event,
  // not against LRCK edges, so LRCK glitches between bit events are ignored.
  logic w_boundary;
  logic w_left_bnd;
  logic w_right_bnd;
  logic w_accept;

  assign w_boundary  = w_bck_fall & (w_lrck != r_lrck_latched);
  assign w_left_bnd  = w_boundary & (w_lrck == CH_LEFT);
  assign w_right_bnd = w_boundary & (w_lrck == CH_RIGHT);
  assign w_accept    = iSAMPLE_VALID & ~r_buf_full;

  always_ff @(posedge AUDIO_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_lrck_latched <= 1'b0;
      r_shreg        <= '0;
      r_act_l        <= '0;
      r_act_r        <= '0;
      r_buf_l        <= '0;
      r_buf_r        <= '0;
      r_buf_full     <= 1'b0;
      r_dacdat       <= 1'b0;
      r_frame_start  <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;

      if (w_bck_fall) begin
        r_lrck_latched <= w_lrck;
        if (w_boundary) begin
          // I2S delay slot: the new word's MSB goes out on the next event.
          r_dacdat <= 1'b0;
        end else begin
          r_dacdat <= r_shreg[DATA_WIDTH-1];
          r_shreg  <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
        end
      end

      if (w_right_bnd) begin
        r_shreg <= r_act_r;
      end

      if (w_left_bnd) begin
        r_frame_start <= 1'b1;
        if (iMUTE) begin
          // Muted frame still drains the buffer but is never an underrun.
          r_act_l    <= '0;
          r_act_r    <= '0;
          r_shreg    <= '0;
          r_buf_full <= 1'b0;
        end else if (r_buf_full) begin
          r_act_l    <= r_buf_l;
          r_act_r    <= r_buf_r;
          r_shreg    <= r_buf_l;
          r_buf_full <= 1'b0;
        end else begin
          r_act_l    <= '0;
          r_act_r    <= '0;
          r_shreg    <= '0;
          r_underrun <= 1'b1;
          if (r_underrun_cnt != {UNDERRUN_W{1'b1}}) begin
            r_underrun_cnt <= r_underrun_cnt + 1'b1;
          end
        end
      end

      // Placed last: a pair accepted on an underrun frame start is held
      // for the following frame.
      if (w_accept) begin
        r_buf_l    <= iSAMPLE_L;
        r_buf_r    <= iSAMPLE_R;
        r_buf_full <= 1'b1;
      end
    end
  end

  assign oSAMPLE_READY = ~r_buf_full;
  assign oAUD_DACDAT   = r_dacdat;
  assign oFRAME_START  = r_frame_start;
  assign oUNDERRUN     = r_underrun;
  assign oUNDERRUN_CNT = r_underrun_cnt;

endmodule

// File: doc/audio_dac_serializer.md
AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bits per channel word.
REQ-002 SHALL have parameter UNDERRUN_W, default 8, underrun counter width.
REQ-003 SHALL have port AUDIO_CLK  input  1  system audio clock; all logic on its rising edge.
REQ-004 SHALL have port iRST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iAUD_BCK  input  1  bit clock from the synth clock generator (AUDIO_CLK-synchronous).
REQ-006 SHALL have port iLRCK  input  1  word clock; 0 = left, 1 = right.
REQ-007 SHALL have port iSAMPLE_L  input  DATA_WIDTH  left sample, two's complement.
REQ-008 SHALL have port iSAMPLE_R  input  DATA_WIDTH  right sample, two's complement.
REQ-009 SHALL have port iSAMPLE_VALID  input  1  producer offers a stereo pair.
REQ-010 SHALL have port oSAMPLE_READY  output  1  holding buffer empty.
REQ-011 SHALL have port iMUTE  input  1  force transmitted words to zero.
REQ-012 SHALL have port oAUD_DACDAT  output  1  serial I2S data.
REQ-013 SHALL have port oFRAME_START  output  1  one-cycle pulse at each left-channel boundary.
REQ-014 SHALL have port oUNDERRUN  output  1  one-cycle pulse on a frame start with an empty buffer.
REQ-015 SHALL have port oUNDERRUN_CNT  output  UNDERRUN_W  saturating underrun count.

Function
REQ-016 SHALL register iAUD_BCK and iLRCK once (bck_r, lrck_r); bit event = bck_r previous 1, current 0.
REQ-017 SHALL act on a bit event at the next AUDIO_CLK edge, so oAUD_DACDAT changes exactly 2 AUDIO_CLK cycles after iAUD_BCK falls.
REQ-018 SHALL latch lrck_r at every bit event; a channel boundary is a bit event whose lrck_r differs from the value latched at the previous bit event.
REQ-019 On a non-boundary bit event SHALL drive oAUD_DACDAT <= shreg MSB and shift shreg left, filling with 0.
REQ-020 On a boundary bit event SHALL drive oAUD_DACDAT <= 0 and load shreg with the new channel word (I2S one-bit delay): MSB appears on the following bit event.
REQ-021 After DATA_WIDTH bits, further bits in the same channel SHALL be 0.
REQ-022 Holding buffer SHALL be one stereo pair; accept on iSAMPLE_VALID & oSAMPLE_READY; oSAMPLE_READY = buffer empty.
REQ-023 At a left boundary (lrck_r 1->0) with buffer full SHALL move the pair into active L/R registers, empty the buffer and load shreg with active L.
REQ-024 At a left boundary with buffer empty SHALL load active L/R with 0, pulse oUNDERRUN, increment oUNDERRUN_CNT saturating at all-ones.
REQ-025 An accept in the same cycle as an underrun frame start SHALL fill the buffer for the next frame only.
REQ-026 At a right boundary (0->1) SHALL load shreg with active R; buffer untouched.
REQ-027 iMUTE sampled at a left boundary SHALL substitute 0 for both words of that frame; the buffer is still consumed; no underrun is flagged.
REQ-028 oFRAME_START SHALL pulse in the cycle the left boundary load occurs.

Reset
REQ-029 SHALL asynchronously clear all registers: oAUD_DACDAT=0, oFRAME_START=0, oUNDERRUN=0, oUNDERRUN_CNT=0, oSAMPLE_READY=1, shreg/active/buffer=0, latched LRCK=0.
REQ-030 Reset mid-frame SHALL discard buffer and shreg; first left boundary after release applies REQ-023/024.

Structure
REQ-031 DATA_WIDTH default, UNDERRUN_W default and channel encoding (LEFT=0, RIGHT=1) SHALL live in shared package synth_audio_pkg.
REQ-032 Edge detection SHALL be sub-module audio_edge_det (registered input, rise/fall pulses), instantiated for BCK and LRCK.

Verification
REQ-033 Pair L=16'hA5C3, R=16'h0F01 accepted before a left boundary -> left slot bits 0,1010010111000011; right slot 0,0000111100000001; oFRAME_START one pulse.
REQ-034 No valid across two frames -> two oUNDERRUN pulses, oUNDERRUN_CNT=2, DACDAT all 0.
REQ-035 Force 260 underruns -> oUNDERRUN_CNT holds 8'hFF.
REQ-036 iMUTE=1 at left boundary with L=16'h7FFF buffered -> frame all 0, oSAMPLE_READY returns 1, no underrun.
REQ-037 iRST_N low mid right slot -> outputs at reset values immediately; next frame after release underruns unless a pair is accepted.
REQ-038 Measure iAUD_BCK fall to oAUD_DACDAT change -> exactly 2 AUDIO_CLK cycles at every bit event.
